// File: rtl/glitch_sequencer.sv
// Glitch sequencer: a byte match on the private or main bus arms a delayed DAC glitch, followed by a hold-off window.
// Optional macro GLITCH_SEQ_TRIG_NACK_EN: a trigger byte must also have been ACKed (nack bit low).
module glitch_sequencer #(
   parameter int DELAY_W = 16,
   parameter int WIDTH_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [8:0]         priv_sda_dec,
   input  logic               priv_ready,
   input  logic [8:0]         main_sda_dec,
   input  logic               main_ready,
   input  logic               arm,
   input  logic [1:0]         match_src,
   input  logic [7:0]         match_byte,
   input  logic [DELAY_W-1:0] delay_cyc,
   input  logic [WIDTH_W-1:0] width_cyc,
   input  logic [7:0]         glitch_level,
   input  logic [7:0]         idle_level,
   input  logic [7:0]         holdoff_cyc,
   output logic [7:0]         dac_level,
   output logic               busy,
   output logic               fired,
   output logic               fire_src,
   output logic [7:0]         fire_count
);

   typedef enum logic [1:0] {IDLE, DELAY, GLITCH, HOLDOFF} state_t;

   localparam logic [DELAY_W-1:0] DLY_ONE  = DELAY_W'(1);
   localparam logic [DELAY_W-1:0] DLY_ZERO = '0;
   localparam logic [WIDTH_W-1:0] WID_ONE  = WIDTH_W'(1);
   localparam logic [WIDTH_W-1:0] WID_ZERO = '0;

   state_t               state_q, state_d;
   logic [DELAY_W-1:0]   dly_cnt_q, dly_cnt_d;
   logic [WIDTH_W-1:0]   wid_cnt_q, wid_cnt_d;
   logic [WIDTH_W-1:0]   wid_lat_q, wid_lat_d;
   logic [7:0]           hold_cnt_q, hold_cnt_d;
   logic [7:0]           hold_lat_q, hold_lat_d;
   logic [7:0]           glvl_lat_q, glvl_lat_d;
   logic [7:0]           dac_level_q, dac_level_d;
   logic                 busy_q, busy_d;
   logic                 fired_q, fired_d;
   logic                 fire_src_q, fire_src_d;
   logic [7:0]           fire_count_q, fire_count_d;
   logic                 priv_hit, main_hit;

   always_comb begin
`ifdef GLITCH_SEQ_TRIG_NACK_EN
      priv_hit = priv_ready & match_src[0] & (priv_sda_dec[8:1] == match_byte) & ~priv_sda_dec[0];
      main_hit = main_ready & match_src[1] & (main_sda_dec[8:1] == match_byte) & ~main_sda_dec[0];
`else
      priv_hit = priv_ready & match_src[0] & (priv_sda_dec[8:1] == match_byte);
      main_hit = main_ready & match_src[1] & (main_sda_dec[8:1] == match_byte);
`endif
   end

   always_comb begin
      state_d      = state_q;
      dly_cnt_d    = dly_cnt_q;
      wid_cnt_d    = wid_cnt_q;
      wid_lat_d    = wid_lat_q;
      hold_cnt_d   = hold_cnt_q;
      hold_lat_d   = hold_lat_q;
      glvl_lat_d   = glvl_lat_q;
      fire_src_d   = fire_src_q;
      fire_count_d = fire_count_q;

      case (state_q)
         IDLE: begin
            if (arm && (priv_hit || main_hit)) begin
               // private bus wins a same-cycle tie
               fire_src_d = ~priv_hit;
               dly_cnt_d  = delay_cyc;
               wid_lat_d  = width_cyc;
               hold_lat_d = holdoff_cyc;
               glvl_lat_d = glitch_level;
               if (delay_cyc == DLY_ZERO) begin
                  state_d   = GLITCH;
                  wid_cnt_d = (width_cyc == WID_ZERO) ? WID_ONE : width_cyc;
               end else begin
                  state_d = DELAY;
               end
            end
         end
         DELAY: begin
            if (!arm) begin
               state_d = IDLE;
            end else if (dly_cnt_q <= DLY_ONE) begin
               state_d   = GLITCH;
               wid_cnt_d = (wid_lat_q == WID_ZERO) ? WID_ONE : wid_lat_q;
            end else begin
               dly_cnt_d = dly_cnt_q - DLY_ONE;
            end
         end
         GLITCH: begin
            if (wid_cnt_q <= WID_ONE) begin
               state_d    = (hold_lat_q == 8'd0) ? IDLE : HOLDOFF;
               hold_cnt_d = hold_lat_q;
            end else begin
               wid_cnt_d = wid_cnt_q - WID_ONE;
            end
         end
         HOLDOFF: begin
            if (hold_cnt_q <= 8'd1) begin
               state_d = IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q - 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // outputs are computed from the next state so they line up with it once registered
      fired_d = (state_d == GLITCH) && (state_q != GLITCH);
      if (fired_d) begin
         fire_count_d = fire_count_q + 8'd1;
      end
      dac_level_d = (state_d == GLITCH) ? glvl_lat_d : idle_level;
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         dly_cnt_q    <= '0;
         wid_cnt_q    <= '0;
         wid_lat_q    <= '0;
         hold_cnt_q   <= '0;
         hold_lat_q   <= '0;
         glvl_lat_q   <= '0;
         dac_level_q  <= '0;
         busy_q       <= 1'b0;
         fired_q      <= 1'b0;
         fire_src_q   <= 1'b0;
         fire_count_q <= '0;
      end else begin
         state_q      <= state_d;
         dly_cnt_q    <= dly_cnt_d;
         wid_cnt_q    <= wid_cnt_d;
         wid_lat_q    <= wid_lat_d;
         hold_cnt_q   <= hold_cnt_d;
         hold_lat_q   <= hold_lat_d;
         glvl_lat_q   <= glvl_lat_d;
         dac_level_q  <= dac_level_d;
         busy_q       <= busy_d;
         fired_q      <= fired_d;
         fire_src_q   <= fire_src_d;
         fire_count_q <= fire_count_d;
      end
   end

   assign dac_level  = dac_level_q;
   assign busy       = busy_q;
   assign fired      = fired_q;
   assign fire_src   = fire_src_q;
   assign fire_count = fire_count_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer: a table of single-trigger scenarios plus hand-written multi-cycle corner cases.
module tb_glitch_sequencer;

   localparam logic [7:0] GL = 8'h3C;
   localparam logic [7:0] IL = 8'h11;

   logic        clk;
   logic        reset;
   logic [8:0]  priv_sda_dec, main_sda_dec;
   logic        priv_ready, main_ready, arm;
   logic [1:0]  match_src;
   logic [7:0]  match_byte;
   logic [15:0] delay_cyc;
   logic [7:0]  width_cyc, glitch_level, idle_level, holdoff_cyc;
   logic [7:0]  dac_level, fire_count;
   logic        busy, fired, fire_src;

   glitch_sequencer dut (
      .clk(clk), .reset(reset),
      .priv_sda_dec(priv_sda_dec), .priv_ready(priv_ready),
      .main_sda_dec(main_sda_dec), .main_ready(main_ready),
      .arm(arm), .match_src(match_src), .match_byte(match_byte),
      .delay_cyc(delay_cyc), .width_cyc(width_cyc),
      .glitch_level(glitch_level), .idle_level(idle_level), .holdoff_cyc(holdoff_cyc),
      .dac_level(dac_level), .busy(busy), .fired(fired),
      .fire_src(fire_src), .fire_count(fire_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  ms;
      logic        pv;
      logic [8:0]  pd;
      logic        mv;
      logic [8:0]  md;
      logic [15:0] dly;
      logic [7:0]  wid;
      logic [7:0]  hold;
      logic        exp_fire;
      logic        exp_src;
      int          start;    // first GLITCH cycle, counted from trigger cycle T
      int          gw;       // glitch length in cycles
      int          idle_at;  // first cycle with busy=0
   } vec_t;

   vec_t        vecs[9];
   int          tests = 0;
   int          fails = 0;
   logic [7:0]  exp_cnt;
   logic        exp_src;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_strobes();
      priv_ready = 1'b0;
      main_ready = 1'b0;
   endtask

   task automatic run_vec(input int i);
      logic [7:0] e_dac;
      logic       e_fired, e_busy;
      match_src    = vecs[i].ms;
      delay_cyc    = vecs[i].dly;
      width_cyc    = vecs[i].wid;
      holdoff_cyc  = vecs[i].hold;
      priv_ready   = vecs[i].pv;
      priv_sda_dec = vecs[i].pd;
      main_ready   = vecs[i].mv;
      main_sda_dec = vecs[i].md;
      tick();
      clear_strobes();
      for (int k = 1; k <= 16; k++) begin
         e_dac   = (vecs[i].exp_fire && k >= vecs[i].start && k < vecs[i].start + vecs[i].gw) ? GL : IL;
         e_fired = vecs[i].exp_fire && (k == vecs[i].start);
         e_busy  = (k < vecs[i].idle_at);
         check($sformatf("vec%0d cyc%0d dac/fired/busy", i, k),
               {22'd0, dac_level, fired, busy}, {22'd0, e_dac, e_fired, e_busy});
         tick();
      end
      if (vecs[i].exp_fire) begin
         exp_cnt = exp_cnt + 8'd1;
         exp_src = vecs[i].exp_src;
      end
      check($sformatf("vec%0d fire_count", i), {24'd0, fire_count}, {24'd0, exp_cnt});
      check($sformatf("vec%0d fire_src", i), {31'd0, fire_src}, {31'd0, exp_src});
   endtask

   initial begin
      vecs[0] = '{2'b01, 1'b1, {8'hA5,1'b0}, 1'b0, 9'h000,      16'd3, 8'd2, 8'd4, 1'b1, 1'b0, 4, 2, 10};
      vecs[1] = '{2'b11, 1'b1, {8'hA5,1'b0}, 1'b1, {8'hA5,1'b0}, 16'd1, 8'd1, 8'd0, 1'b1, 1'b0, 2, 1, 3};
      vecs[2] = '{2'b10, 1'b0, 9'h000,       1'b1, {8'hA5,1'b0}, 16'd2, 8'd3, 8'd1, 1'b1, 1'b1, 3, 3, 7};
      vecs[3] = '{2'b01, 1'b0, 9'h000,       1'b1, {8'hA5,1'b0}, 16'd0, 8'd1, 8'd0, 1'b0, 1'b0, 0, 0, 1};
      vecs[4] = '{2'b01, 1'b1, {8'h5A,1'b0}, 1'b0, 9'h000,      16'd0, 8'd1, 8'd0, 1'b0, 1'b0, 0, 0, 1};
      vecs[5] = '{2'b01, 1'b1, {8'hA5,1'b0}, 1'b0, 9'h000,      16'd0, 8'd0, 8'd2, 1'b1, 1'b0, 1, 1, 4};
`ifdef GLITCH_SEQ_TRIG_NACK_EN
      vecs[6] = '{2'b01, 1'b1, {8'hA5,1'b1}, 1'b0, 9'h000,      16'd0, 8'd1, 8'd0, 1'b0, 1'b0, 0, 0, 1};
`else
      vecs[6] = '{2'b01, 1'b1, {8'hA5,1'b1}, 1'b0, 9'h000,      16'd0, 8'd1, 8'd0, 1'b1, 1'b0, 1, 1, 2};
`endif
      vecs[7] = '{2'b11, 1'b1, {8'h5A,1'b0}, 1'b1, {8'hA5,1'b0}, 16'd1, 8'd2, 8'd0, 1'b1, 1'b1, 2, 2, 4};
      vecs[8] = '{2'b10, 1'b1, {8'hA5,1'b0}, 1'b1, {8'h5A,1'b0}, 16'd0, 8'd1, 8'd0, 1'b0, 1'b0, 0, 0, 1};

      reset = 1'b1;
      priv_sda_dec = '0; main_sda_dec = '0;
      clear_strobes();
      arm = 1'b1; match_src = 2'b01; match_byte = 8'hA5;
      delay_cyc = '0; width_cyc = '0; holdoff_cyc = '0;
      glitch_level = GL; idle_level = IL;
      exp_cnt = 8'd0; exp_src = 1'b0;

      #2 reset = 1'b0;
      #10;
      check("reset dac", {24'd0, dac_level}, 32'h00);
      check("reset busy/fired/src", {29'd0, busy, fired, fire_src}, 32'd0);
      check("reset fire_count", {24'd0, fire_count}, 32'd0);
      @(posedge clk); #1 reset = 1'b1;
      tick();
      check("first edge dac=idle", {24'd0, dac_level}, {24'd0, IL});

      for (int i = 0; i < 9; i++) run_vec(i);

      // idle_level followed live while idle
      idle_level = 8'h22;
      tick();
      check("idle tracks idle_level", {24'd0, dac_level}, 32'h22);
      idle_level = IL;
      tick();

      // second hit during hold-off is dropped
      match_src = 2'b01; delay_cyc = 16'd0; width_cyc = 8'd0; holdoff_cyc = 8'd5;
      priv_sda_dec = {8'hA5, 1'b0}; priv_ready = 1'b1;
      tick(); clear_strobes();
      check("holdoff seq glitch", {22'd0, dac_level, fired, busy}, {22'd0, GL, 1'b1, 1'b1});
      exp_cnt = exp_cnt + 8'd1;
      tick();
      priv_ready = 1'b1;
      tick(); clear_strobes();
      for (int k = 3; k <= 9; k++) begin
         check($sformatf("holdoff seq cyc%0d dac/fired", k), {23'd0, dac_level, fired}, {23'd0, IL, 1'b0});
         tick();
      end
      check("holdoff seq busy end", {31'd0, busy}, 32'd0);
      check("holdoff seq count", {24'd0, fire_count}, {24'd0, exp_cnt});

      // arm dropped during DELAY aborts with no fire
      delay_cyc = 16'd10; width_cyc = 8'd1; holdoff_cyc = 8'd0;
      priv_ready = 1'b1;
      tick(); clear_strobes();
      tick();
      arm = 1'b0;
      tick();
      check("abort busy at T+3", {31'd0, busy}, 32'd0);
      for (int k = 4; k <= 14; k++) begin
         tick();
         check($sformatf("abort cyc%0d dac/fired", k), {23'd0, dac_level, fired}, {23'd0, IL, 1'b0});
      end
      check("abort count", {24'd0, fire_count}, {24'd0, exp_cnt});
      arm = 1'b1;

      // parameter changes after trigger are ignored
      delay_cyc = 16'd2; width_cyc = 8'd2; holdoff_cyc = 8'd0;
      priv_ready = 1'b1;
      tick(); clear_strobes();
      glitch_level = 8'hFF; width_cyc = 8'd9; delay_cyc = 16'd0; holdoff_cyc = 8'd7;
      tick();
      tick();
      check("latched glitch T+3", {22'd0, dac_level, fired, busy}, {22'd0, GL, 1'b1, 1'b1});
      tick();
      check("latched glitch T+4", {22'd0, dac_level, fired, busy}, {22'd0, GL, 1'b0, 1'b1});
      tick();
      check("latched end T+5", {22'd0, dac_level, fired, busy}, {22'd0, IL, 1'b0, 1'b0});
      exp_cnt = exp_cnt + 8'd1;
      glitch_level = GL;

      // arm dropped during GLITCH does not abort
      delay_cyc = 16'd0; width_cyc = 8'd3; holdoff_cyc = 8'd2;
      priv_ready = 1'b1;
      tick(); clear_strobes();
      arm = 1'b0;
      check("noabort cyc1", {22'd0, dac_level, fired, busy}, {22'd0, GL, 1'b1, 1'b1});
      for (int k = 2; k <= 6; k++) begin
         tick();
         check($sformatf("noabort cyc%0d dac/busy", k), {23'd0, dac_level, busy},
               {23'd0, (k <= 3) ? GL : IL, (k <= 5)});
      end
      exp_cnt = exp_cnt + 8'd1;
      check("noabort count", {24'd0, fire_count}, {24'd0, exp_cnt});
      arm = 1'b1;

      // asynchronous reset mid-glitch
      delay_cyc = 16'd0; width_cyc = 8'd5; holdoff_cyc = 8'd0;
      priv_ready = 1'b1;
      tick(); clear_strobes();
      tick();
      check("pre-reset in glitch", {24'd0, dac_level}, {24'd0, GL});
      #2 reset = 1'b0;
      #1;
      check("async reset dac", {24'd0, dac_level}, 32'h00);
      check("async reset busy/fired/src", {29'd0, busy, fired, fire_src}, 32'd0);
      check("async reset count", {24'd0, fire_count}, 32'd0);
      exp_cnt = 8'd0; exp_src = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      tick();
      check("post-reset dac/busy", {23'd0, dac_level, busy}, {23'd0, IL, 1'b0});

      // fire_count wraps after 256 fires
      delay_cyc = 16'd0; width_cyc = 8'd0; holdoff_cyc = 8'd0;
      priv_ready = 1'b1;
      for (int i = 0; i < 255; i++) begin
         tick();
         tick();
      end
      check("count at 255", {24'd0, fire_count}, 32'd255);
      tick();
      clear_strobes();
      check("wrap fired", {31'd0, fired}, 32'd1);
      check("wrap count 0", {24'd0, fire_count}, 32'd0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/glitch_sequencer.md
GLITCH_SEQUENCER -- requirements
Module: glitch_sequencer

Interface
REQ-001 Parameter DELAY_W, default 16, width of the trigger-to-glitch delay counter.
REQ-002 Parameter WIDTH_W, default 8, width of the glitch pulse-width counter.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-005 priv_sda_dec  input  9  decoded private-bus byte: [8:1] data, [0] nack.
REQ-006 priv_ready  input  1  one-cycle strobe; priv_sda_dec is valid in that cycle.
REQ-007 main_sda_dec  input  9  decoded main-bus byte, same format as priv_sda_dec.
REQ-008 main_ready  input  1  one-cycle strobe for main_sda_dec.
REQ-009 arm  input  1  level; 1 permits triggering.
REQ-010 match_src  input  2  bit0 enables the private bus as a trigger source; bit1 enables the main bus.
REQ-011 match_byte  input  8  trigger byte value.
REQ-012 delay_cyc  input  DELAY_W  cycles from trigger to glitch.
REQ-013 width_cyc  input  WIDTH_W  glitch length in cycles.
REQ-014 glitch_level, idle_level  input  8 each  DAC codes during glitch and otherwise.
REQ-015 holdoff_cyc  input  8  dead time after a glitch.
REQ-016 dac_level  output  8  registered DAC code.
REQ-017 busy  output  1  1 when state is not IDLE.
REQ-018 fired  output  1  one-cycle pulse on the first GLITCH cycle.
REQ-019 fire_src  output  1  source of the last fire: 0 = private, 1 = main.
REQ-020 fire_count  output  8  number of glitches fired, modulo 256.

Function
REQ-021 States: IDLE, DELAY, GLITCH, HOLDOFF; all outputs are registered.
REQ-022 A priv hit is priv_ready & match_src[0] & (priv_sda_dec[8:1]==match_byte); a main hit is defined identically on main_*.
REQ-023 In IDLE with arm=1 and any hit at cycle T, the block latches delay_cyc, width_cyc, glitch_level and holdoff_cyc, and sets fire_src to the source.
REQ-024 Simultaneous priv and main hits: private wins, fire_src=0, and the main hit is dropped.
REQ-025 Trigger at T with delay_cyc=D>=1: DELAY spans T+1..T+D and GLITCH begins at T+D+1; with D=0, GLITCH begins at T+1.
REQ-026 GLITCH lasts max(width_cyc,1) cycles, with dac_level = latched glitch_level throughout.
REQ-027 HOLDOFF lasts latched holdoff_cyc cycles, then the block goes to IDLE; holdoff_cyc=0 goes directly from GLITCH to IDLE.
REQ-028 In IDLE, DELAY and HOLDOFF, dac_level = current idle_level, sampled each cycle.
REQ-029 Hits outside IDLE are ignored and not queued.
REQ-030 arm=0 during DELAY aborts to IDLE on the next edge with no fire, and fire_count is unchanged.
REQ-031 arm=0 during GLITCH or HOLDOFF does not abort; the sequence completes.
REQ-032 fired=1 for exactly the first GLITCH cycle, and fire_count increments in that cycle, wrapping 255->0.
REQ-033 Changes to delay/width/level/holdoff inputs after the trigger do not affect the sequence in flight.

Reset
REQ-034 While reset=0: state=IDLE, dac_level=8'h00, busy=0, fired=0, fire_src=0, fire_count=0, and all counters and latched values are 0.
REQ-035 Reset asserted mid-sequence (any state) takes effect asynchronously; dac_level drops to 8'h00 immediately, with no fired pulse.
REQ-036 From the first clk edge after reset deassertion, dac_level = idle_level.

Configuration
REQ-037 Macro GLITCH_SEQ_TRIG_NACK_EN: when defined, a hit additionally requires the nack bit ([0]) = 0 (ACKed byte); when undefined, the nack bit is ignored.

Verification
REQ-038 arm=1, match_src=01, match_byte=8'hA5, delay=3, width=2, holdoff=4, priv strobe with 8'hA5 at T -> dac=glitch_level at T+4..T+5, fired at T+4, busy is 0 again from T+10, fire_count=1.
REQ-039 Both buses strobe 8'hA5 in the same cycle with match_src=11 -> exactly one glitch, fire_src=0.
REQ-040 delay=0, width=0 -> a one-cycle glitch at T+1; a second hit during HOLDOFF -> no second glitch.
REQ-041 arm dropped at T+2 with delay=10 -> no glitch, fire_count unchanged, busy=0 at T+3; reset pulsed during GLITCH -> dac=8'h00 asynchronously.
REQ-042 Byte 8'hA5 with nack=1 -> a glitch only when GLITCH_SEQ_TRIG_NACK_EN is undefined; 256 fires -> fire_count wraps to 0.
